rx_byte_collector: RTL and testbench

- Sits directly downstream of the serial receiver's bit sampler.
- Takes the sampler's one-cycle `sample_sig` strobes and the serial line `din`, and assembles 8 data bits, LSB first, into a byte.
- Queues completed bytes in a small FIFO and presents them on a valid/ready interface to the host-side logic.
- Also flags FIFO overflow and discards stalled partial frames after a timeout.

---
 rtl/rx_byte_collector_if.sv | 13 +
 rtl/rx_byte_collector.sv | 74 +++++++
 tb/tb_rx_byte_collector.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rx_byte_collector_if.sv
// rx_byte_collector_if: valid/ready byte stream from the collector to host-side logic
// Ports (signals):
//   data_out   byte at the FIFO head, 0x00 when empty
//   data_valid FIFO not empty
//   data_ready consumer takes data_out when high together with data_valid
// Modports: master = producer (collector), slave = consumer.
interface rx_byte_collector_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  modport master (output data_out, data_valid, input data_ready);
  modport slave  (input data_out, data_valid, output data_ready);
endinterface

// File: rtl/rx_byte_collector.sv
// rx_byte_collector: assembles LSB-first serial bits into bytes and queues them in a FIFO
// Ports:
//   sample_clk   clock shared with the bit sampler
//   rst_n        asynchronous reset, active low
//   sample_sig   sampler strobe, din is sampled in this cycle
//   din          serial line
//   bus          master side of the valid/ready byte stream
//   fill_level   FIFO occupancy
//   overflow     sticky flag, a byte was dropped
//   clr_overflow synchronous clear of overflow
//   frame_err    one-cycle pulse, a stalled partial byte was discarded
module rx_byte_collector #(
  parameter int SAMPLE_RATIO = 16,
  parameter int TIMEOUT      = 32,
  parameter int DEPTH        = 4
) (
  input  logic                     sample_clk,
  input  logic                     rst_n,
  input  logic                     sample_sig,
  input  logic                     din,
  rx_byte_collector_if.master      bus,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic                     frame_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  if (SAMPLE_RATIO < 1 || TIMEOUT < 2 || TIMEOUT > 255 || DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("rx_byte_collector: parameter out of range");
  end
  logic [7:0]    shift, idle_cnt, nb;
  logic [2:0]    bit_cnt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          push, pop, wr, drop, timeout, full;
  assign nb      = {din, shift[7:1]};
  assign push    = sample_sig && bit_cnt == 3'd7;
  assign full    = count == CW'(DEPTH);
  assign pop     = bus.data_valid && bus.data_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign wr      = push && (!full || pop);
  assign drop    = push && full && !pop;
  // a strobe coinciding with the timeout wins
  assign timeout = !sample_sig && bit_cnt != 3'd0 && idle_cnt == 8'(TIMEOUT - 1);
  assign bus.data_valid = count != '0;
  assign bus.data_out   = bus.data_valid ? mem[rd_ptr] : 8'h00;
  assign fill_level     = count;
  always_ff @(posedge sample_clk)
    if (wr) mem[wr_ptr] <= nb;
  always_ff @(posedge sample_clk or negedge rst_n)
    if (!rst_n) begin
      shift     <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= timeout;
      if (sample_sig) begin
        shift   <= nb;
        bit_cnt <= bit_cnt + 3'd1;
      end else if (timeout) bit_cnt <= 3'd0;
      idle_cnt <= (sample_sig || bit_cnt == 3'd0 || timeout) ? 8'd0 : idle_cnt + 8'd1;
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count    <= count + CW'(wr) - CW'(pop);
      overflow <= drop || (overflow && !clr_overflow);
    end
endmodule

// File: tb/tb_rx_byte_collector.sv
// tb_rx_byte_collector: directed checks of byte assembly, FIFO, overflow, timeout and reset
module tb_rx_byte_collector;
  logic       sample_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_sig = 1'b0;
  logic       din = 1'b0;
  logic [2:0] fill_level;
  logic       overflow;
  logic       clr_overflow = 1'b0;
  logic       frame_err;
  int         n = 0;
  int         errs = 0;
  bit         mon = 1'b0;
  bit         fe_seen;
  int         maxf;
  logic [7:0] seen [$];
  rx_byte_collector_if bus ();
  rx_byte_collector #(.SAMPLE_RATIO(16), .TIMEOUT(32), .DEPTH(4)) dut (
    .sample_clk  (sample_clk),
    .rst_n       (rst_n),
    .sample_sig  (sample_sig),
    .din         (din),
    .bus         (bus),
    .fill_level  (fill_level),
    .overflow    (overflow),
    .clr_overflow(clr_overflow),
    .frame_err   (frame_err)
  );
  always #5 sample_clk = ~sample_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge sample_clk);
    #1;
    if (frame_err) fe_seen = 1'b1;
    if (mon) begin
      if (bus.data_valid) seen.push_back(bus.data_out);
      if (int'(fill_level) > maxf) maxf = int'(fill_level);
    end
  endtask
  task automatic strobe(input logic b);
    sample_sig = 1'b1;
    din = b;
    tick();
    sample_sig = 1'b0;
    din = 1'b0;
  endtask
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit pop_last);
    for (int i = 0; i < nbits; i++) begin
      repeat (15) tick();
      if (pop_last && i == 7) bus.data_ready = 1'b1;
      strobe(b[i]);
    end
    if (pop_last) bus.data_ready = 1'b0;
  endtask
  initial begin
    bus.data_ready = 1'b0;
    #12;
    chk("reset_valid", bus.data_valid, 0);
    chk("reset_data", bus.data_out, 0);
    chk("reset_fill", fill_level, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_ferr", frame_err, 0);
    rst_n = 1'b1;
    tick();
    // 1: single byte, latency and pop
    send_bits(8'hA5, 7, 1'b0);
    repeat (15) tick();
    chk("t1_valid_before", bus.data_valid, 0);
    strobe(1'b1);
    chk("t1_valid", bus.data_valid, 1);
    chk("t1_data", bus.data_out, 8'hA5);
    chk("t1_fill", fill_level, 1);
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    chk("t1_fill_pop", fill_level, 0);
    chk("t1_valid_pop", bus.data_valid, 0);
    // 2: streaming with ready held high
    bus.data_ready = 1'b1;
    seen.delete();
    maxf = 0;
    mon = 1'b1;
    send_bits(8'h00, 8, 1'b0);
    send_bits(8'hFF, 8, 1'b0);
    repeat (3) tick();
    mon = 1'b0;
    bus.data_ready = 1'b0;
    chk("t2_count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("t2_first", seen[0], 8'h00);
      chk("t2_second", seen[1], 8'hFF);
    end
    chk("t2_maxfill", maxf, 1);
    // 3: fill, overflow, drain, clear
    send_bits(8'h11, 8, 1'b0);
    send_bits(8'h22, 8, 1'b0);
    send_bits(8'h33, 8, 1'b0);
    send_bits(8'h44, 8, 1'b0);
    chk("t3_fill4", fill_level, 4);
    chk("t3_ovf_before", overflow, 0);
    send_bits(8'h55, 8, 1'b0);
    chk("t3_ovf", overflow, 1);
    chk("t3_fill_after_drop", fill_level, 4);
    bus.data_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t3_drain", bus.data_out, 32'(i * 8'h11));
      tick();
    end
    bus.data_ready = 1'b0;
    chk("t3_empty", fill_level, 0);
    chk("t3_ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("t3_ovf_clr", overflow, 0);
    // 4: push into full FIFO coinciding with pop
    send_bits(8'h01, 8, 1'b0);
    send_bits(8'h02, 8, 1'b0);
    send_bits(8'h03, 8, 1'b0);
    send_bits(8'h04, 8, 1'b0);
    send_bits(8'h66, 8, 1'b1);
    chk("t4_fill", fill_level, 4);
    chk("t4_ovf", overflow, 0);
    bus.data_ready = 1'b1;
    chk("t4_d2", bus.data_out, 8'h02);
    tick();
    chk("t4_d3", bus.data_out, 8'h03);
    tick();
    chk("t4_d4", bus.data_out, 8'h04);
    tick();
    chk("t4_d66", bus.data_out, 8'h66);
    tick();
    bus.data_ready = 1'b0;
    chk("t4_empty", bus.data_valid, 0);
    // 5: timeout after 3 strobes
    send_bits(8'hFF, 3, 1'b0);
    fe_seen = 1'b0;
    repeat (31) tick();
    chk("t5_no_early_ferr", fe_seen, 0);
    tick();
    chk("t5_ferr", frame_err, 1);
    tick();
    chk("t5_ferr_pulse", frame_err, 0);
    send_bits(8'h3C, 8, 1'b0);
    chk("t5_data", bus.data_out, 8'h3C);
    chk("t5_fill", fill_level, 1);
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    // 6: asynchronous reset mid-byte with data queued
    send_bits(8'h12, 8, 1'b0);
    send_bits(8'h34, 8, 1'b0);
    send_bits(8'hFF, 4, 1'b0);
    chk("t6_fill_pre", fill_level, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", bus.data_valid, 0);
    chk("t6_data", bus.data_out, 0);
    chk("t6_fill", fill_level, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_ferr", frame_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_bits(8'hC3, 8, 1'b0);
    chk("t6_data_after", bus.data_out, 8'hC3);
    chk("t6_fill_after", fill_level, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
